// File: rtl/ssd_display_scheduler.sv
// rtl/ssd_display_scheduler.sv - round-robin scheduler for a two-digit SSD
// Grants one of four requesters, blanks the display briefly, then shows the byte for a dwell time.
module ssd_display_scheduler #(
  parameter int PAR_DWELL_CYCLES = 20000000,
  parameter int PAR_BLANK_CYCLES = 200000
) (
  input  logic       i_clk_20mhz,
  input  logic       i_rst_20mhz,
  input  logic [3:0] i_req,
  input  logic [7:0] i_value0,
  input  logic [7:0] i_value1,
  input  logic [7:0] i_value2,
  input  logic [7:0] i_value3,
  input  logic       i_hold,
  output logic [3:0] o_ack,
  output logic [7:0] o_value,
  output logic [1:0] o_src_id,
  output logic       o_blank
);

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;

  // Counters hold "remaining cycles minus one", so zero means the interval ends at the next edge.
  localparam logic [24:0] BLANK_LOAD = 25'(PAR_BLANK_CYCLES - 1);
  localparam logic [24:0] DWELL_LOAD = 25'(PAR_DWELL_CYCLES - 1);

  state_t      state, state_next;
  logic [24:0] blank_cnt;
  logic [24:0] dwell_cnt;
  logic [1:0]  last_idx;
  logic [1:0]  cand;
  logic [1:0]  grant_idx;
  logic        grant_found;
  logic        grant;
  logic [7:0]  sel_value;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_idx + 2'(k);
      if (!grant_found && i_req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end

    grant = grant_found && !i_hold &&
            (state == ST_IDLE || (state == ST_SHOW && dwell_cnt == 25'd0));

    case (grant_idx)
      2'd0:    sel_value = i_value0;
      2'd1:    sel_value = i_value1;
      2'd2:    sel_value = i_value2;
      default: sel_value = i_value3;
    endcase

    state_next = state;
    case (state)
      ST_IDLE:  if (grant) state_next = ST_BLANK;
      ST_BLANK: if (blank_cnt == 25'd0) state_next = ST_SHOW;
      ST_SHOW:  if (grant) state_next = ST_BLANK;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      state     <= ST_IDLE;
      o_ack     <= 4'b0000;
      o_value   <= 8'h00;
      o_src_id  <= 2'd0;
      o_blank   <= 1'b1;
      blank_cnt <= 25'd0;
      dwell_cnt <= 25'd0;
      last_idx  <= 2'd3;
    end else begin
      state <= state_next;
      o_ack <= 4'b0000;
      if (grant) begin
        o_ack     <= 4'b0001 << grant_idx;
        o_value   <= sel_value;
        o_src_id  <= grant_idx;
        o_blank   <= 1'b1;
        blank_cnt <= BLANK_LOAD;
        last_idx  <= grant_idx;
      end else begin
        case (state)
          ST_BLANK: begin
            if (blank_cnt == 25'd0) begin
              o_blank   <= 1'b0;
              dwell_cnt <= DWELL_LOAD;
            end else begin
              blank_cnt <= blank_cnt - 25'd1;
            end
          end
          ST_SHOW: begin
            if (!i_hold && dwell_cnt != 25'd0) dwell_cnt <= dwell_cnt - 25'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ssd_display_scheduler.sv
// tb/tb_ssd_display_scheduler.sv - randomized bench for ssd_display_scheduler
// Predicts every output cycle from a timing-level model of grant, blank and dwell intervals.
module tb_ssd_display_scheduler;
  localparam int DWELL = 8;
  localparam int BLANK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [7:0] v0 = 8'h00, v1 = 8'h00, v2 = 8'h00, v3 = 8'h00;
  logic       hold = 1'b0;
  logic [3:0] ack;
  logic [7:0] value;
  logic [1:0] src_id;
  logic       blank;

  int checks = 0;
  int failures = 0;

  ssd_display_scheduler #(.PAR_DWELL_CYCLES(DWELL), .PAR_BLANK_CYCLES(BLANK)) dut (
    .i_clk_20mhz(clk),
    .i_rst_20mhz(rst),
    .i_req(req),
    .i_value0(v0),
    .i_value1(v1),
    .i_value2(v2),
    .i_value3(v3),
    .i_hold(hold),
    .o_ack(ack),
    .o_value(value),
    .o_src_id(src_id),
    .o_blank(blank)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Model: mode 0 = nothing granted yet, 1 = blanking, 2 = showing.
  int         m_mode;
  int         m_count;
  int         m_last;
  logic [3:0] e_ack;
  logic [7:0] e_value;
  logic [1:0] e_src;
  logic       e_blank;

  function automatic logic [7:0] value_of(input int n);
    case (n)
      0:       return v0;
      1:       return v1;
      2:       return v2;
      default: return v3;
    endcase
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_count = 0;
    m_last  = 3;
    e_ack   = 4'b0000;
    e_value = 8'h00;
    e_src   = 2'd0;
    e_blank = 1'b1;
  endtask

  task automatic model_step();
    int  pick;
    bit  may_grant;
    pick      = -1;
    may_grant = 0;
    e_ack     = 4'b0000;
    if (m_mode == 1) begin
      m_count++;
      if (m_count == BLANK) begin
        m_mode  = 2;
        m_count = 0;
        e_blank = 1'b0;
      end
    end else begin
      if (m_mode == 2 && !hold) m_count++;
      may_grant = !hold && (m_mode == 0 || m_count >= DWELL);
    end
    if (may_grant) begin
      for (int off = 1; off <= 4; off++) begin
        int n;
        n = (m_last + off) % 4;
        if (pick < 0 && req[n]) pick = n;
      end
    end
    if (pick >= 0) begin
      e_ack   = 4'(1 << pick);
      e_value = value_of(pick);
      e_src   = 2'(pick);
      e_blank = 1'b1;
      m_mode  = 1;
      m_count = 0;
      m_last  = pick;
    end
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else model_step();
  end

  task automatic check_outputs();
    expect_eq("ack", ack, e_ack);
    expect_eq("value", value, e_value);
    expect_eq("src_id", src_id, e_src);
    expect_eq("blank", blank, e_blank);
  endtask

  // One cycle: check at the falling edge, consume acks, then optionally redraw inputs.
  task automatic cycle(input bit rnd, input int raise_mod, input int hold_mod);
    @(negedge clk);
    check_outputs();
    req = req & ~e_ack;
    if (rnd) begin
      for (int n = 0; n < 4; n++) begin
        if (!req[n]) begin
          if (raise_mod > 0 && $urandom_range(raise_mod - 1) == 0) req[n] = 1'b1;
        end else if ($urandom_range(39) == 0) begin
          req[n] = 1'b0;
        end
      end
      hold = (hold_mod > 0) && ($urandom_range(hold_mod - 1) == 0);
      v0 = 8'($urandom);
      v1 = 8'($urandom);
      v2 = 8'($urandom);
      v3 = 8'($urandom);
    end
  endtask

  task automatic async_reset_mid_show();
    int budget;
    budget = 0;
    while (!(m_mode == 2 && m_count == 3) && budget < 300) begin
      cycle(1, 2, 0);
      budget++;
    end
    expect_eq("reach_show", (budget < 300), 1);
    hold = 1'b0;
    #2 rst = 1'b1;
    #1;
    expect_eq("async_ack", ack, 4'b0000);
    expect_eq("async_value", value, 8'h00);
    expect_eq("async_src", src_id, 2'd0);
    expect_eq("async_blank", blank, 1'b1);
    model_reset();
    req = 4'b0000;
    repeat (3) cycle(0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst  = 1'b0;
    req  = 4'b0001;
    v0   = 8'h3C;
    repeat (14) cycle(0, 0, 0);
    req = 4'b1111;
    repeat (45) cycle(0, 0, 0);
    repeat (400) cycle(1, 3, 0);
    repeat (60) cycle(1, 0, 0);
    repeat (400) cycle(1, 5, 6);
    async_reset_mid_show();
    repeat (400) cycle(1, 2, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd_display_scheduler.md
SSD_DISPLAY_SCHEDULER -- requirements
Module: ssd_display_scheduler

Interface
REQ-001 Parameter: PAR_DWELL_CYCLES, default 20000000, number of clock cycles a granted value is shown before rotation is allowed (1 s at 20 MHz); legal range 2..2^25-1.
REQ-002 Parameter: PAR_BLANK_CYCLES, default 200000, number of clock cycles the display is blanked between two granted values (10 ms at 20 MHz); legal range 1..2^25-1.
REQ-003 i_clk_20mhz  input  1  sole clock; all state changes on its rising edge.
REQ-004 i_rst_20mhz  input  1  reset, asynchronous and active-high.
REQ-005 i_req  input  4  per-requester level request; bit n held high until o_ack[n].
REQ-006 i_value0..i_value3  input  8 each  display byte of requester n; sampled only in the cycle o_ack[n] is high.
REQ-007 i_hold  input  1  when high, freezes the dwell counter and inhibits new grants.
REQ-008 o_ack  output  4  one-hot, single-cycle grant acknowledge.
REQ-009 o_value  output  8  byte for the two-digit SSD converter (upper nibble left digit).
REQ-010 o_src_id  output  2  index of the requester whose byte is on o_value.
REQ-011 o_blank  output  1  high = downstream SSD shall show no segments.

Function
REQ-012 States: IDLE (nothing granted yet), BLANK, SHOW; all outputs registered.
REQ-013 Grant condition: (state IDLE, or SHOW with dwell expired) and i_hold low and i_req nonzero.
REQ-014 Arbitration round-robin: search starts at (last granted index + 1) mod 4; after reset search starts at index 0.
REQ-015 On grant to n: o_ack[n]=1 for exactly the next cycle, o_value<=i_value<n> and o_src_id<=n in that same cycle, state->BLANK, blank counter loaded.
REQ-016 Grant latency: i_req[n] high at edge k in a grant-eligible state -> o_ack[n], o_value, o_blank=1 all valid after edge k.
REQ-017 o_ack at most one bit high; never two consecutive high cycles for the same requester.
REQ-018 A requester whose i_req falls before its ack is not granted (withdrawn, no error).
REQ-019 BLANK: o_blank=1 for exactly PAR_BLANK_CYCLES cycles, then state->SHOW, o_blank=0, dwell counter loaded.
REQ-020 SHOW: dwell counter decrements each cycle while i_hold low; expiry after PAR_DWELL_CYCLES unheld cycles; counter saturates at 0 (no wrap).
REQ-021 SHOW with dwell expired and no request: remain SHOW, o_value/o_src_id unchanged indefinitely.
REQ-022 Sole pending requester equal to the currently shown source is re-granted normally (value refresh, including BLANK interval).
REQ-023 i_hold high in BLANK: blank counter continues; i_hold affects only dwell counting and grants.
REQ-024 i_hold deasserted with dwell expired and request pending: grant on the next edge per REQ-016.
REQ-025 Counters 25 bits unsigned; no arithmetic overflow for legal parameters.

Reset
REQ-026 While i_rst_20mhz high, asynchronously: state IDLE, o_ack=0000, o_value=0x00, o_src_id=0, o_blank=1, counters 0, round-robin pointer such that index 0 is searched first.
REQ-027 Reset asserted mid-BLANK or mid-SHOW aborts immediately to REQ-026 values; no ack issued in the reset-release cycle unless i_req is sampled high at the first edge after release.

Verification (bench uses PAR_DWELL_CYCLES=8, PAR_BLANK_CYCLES=2)
REQ-028 Reset release, i_req=0001, i_value0=0x3C -> o_ack=0001 one cycle, o_value=0x3C, o_src_id=0, o_blank=1 two cycles, then o_blank=0 for 8 cycles.
REQ-029 i_req=1111 held (acks consumed) -> grant order 0,1,2,3,0; consecutive acks exactly 10 cycles apart.
REQ-030 After showing source 2, i_req=0000 -> o_value and o_src_id=2 stable for 50 cycles, o_blank=0; then i_req=0010 -> ack on next edge.
REQ-031 i_hold high for 5 cycles mid-SHOW with i_req=0100 pending -> expiry and ack delayed exactly 5 cycles.
REQ-032 Assert reset at cycle 4 of SHOW with o_value=0xA5 -> outputs 0x00, o_blank=1, o_ack=0000 without waiting for a clock edge.
REQ-033 i_req[1] pulsed high then low during SHOW before expiry -> no o_ack[1] ever issued.
